// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcodes, scheduler state encoding and ALU flag bundle shared by alu_rr_scheduler and alu_core
package alu_sched_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic sign;
    logic err;
  } flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ADD/SUB/AND/OR with carry/zero/overflow/sign and unsupported-opcode flag
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           is_add;
  logic           is_sub;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign is_add = opcode == OP_ADD;
  assign is_sub = opcode == OP_SUB;
  always_comb begin
    result = is_add ? sum[WIDTH-1:0] :
             is_sub ? diff[WIDTH-1:0] :
             opcode == OP_AND ? (a & b) :
             opcode == OP_OR  ? (a | b) : '0;
    flags.carry    = is_add ? sum[WIDTH] : is_sub ? diff[WIDTH] : 1'b0;
    flags.overflow = is_add ? (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) :
                     is_sub ? (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    flags.zero     = result == '0;
    flags.sign     = result[WIDTH-1];
    flags.err      = opcode > OP_OR;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU among NUM_REQ requesters with a registered, backpressured response.
// Define ALU_SCHED_STATS_EN to add saturating ops_count/err_count handshake counters.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
  output logic                   rsp_sign,
  output logic                   rsp_err
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]            ops_count,
  output logic [7:0]             err_count
`endif
);
  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] alu_result;
  flags_t           alu_flags;
  logic             rsp_fire;
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .flags  (alu_flags)
  );
  // first valid requester at or after rr_ptr, wrapping at NUM_REQ-1
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
  assign rsp_fire  = rsp_valid && rsp_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_sign     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_q  <= req_opcode[4*gnt +: 4];
          a_q   <= req_a[WIDTH*gnt +: WIDTH];
          b_q   <= req_b[WIDTH*gnt +: WIDTH];
          id_q  <= gnt;
          state <= EXEC;
        end
        EXEC: begin
          rsp_valid    <= 1'b1;
          rsp_id       <= id_q;
          rsp_result   <= alu_result;
          rsp_carry    <= alu_flags.carry;
          rsp_zero     <= alu_flags.zero;
          rsp_overflow <= alu_flags.overflow;
          rsp_sign     <= alu_flags.sign;
          rsp_err      <= alu_flags.err;
          state        <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= ID_W'((int'(rsp_id) + 1) % NUM_REQ);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_count <= '0;
      err_count <= '0;
    end else if (rsp_fire) begin
      ops_count <= ops_count == 16'hFFFF ? ops_count : ops_count + 16'd1;
      err_count <= (rsp_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed self-checking bench for alu_rr_scheduler (default NUM_REQ=4, WIDTH=8).
// Adds counter checks when ALU_SCHED_STATS_EN is defined.
module tb_alu_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_carry, rsp_zero, rsp_overflow, rsp_sign, rsp_err;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] ops_count;
  logic [7:0]  err_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] fair_res [4];
  logic [7:0] held_result;

  alu_rr_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_sign     (rsp_sign),
    .rsp_err      (rsp_err)
`ifdef ALU_SCHED_STATS_EN
    ,
    .ops_count    (ops_count),
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {rsp_carry, rsp_zero, rsp_overflow, rsp_sign, rsp_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[4*i +: 4] = op;
    req_a[8*i +: 8]      = a;
    req_b[8*i +: 8]      = b;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_op(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    set_req(i, op, a, b);
    req_valid = 4'b1 << i;
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp();
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    req_opcode = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_data", {22'd0, rsp_id, rsp_result}, 32'd0);
    chk("reset_flags", 32'(flags()), 32'd0);
`ifdef ALU_SCHED_STATS_EN
    chk("reset_stats", {8'd0, ops_count, err_count}, 32'd0);
`endif
    rst_n = 1'b1;
    // single ADD on requester 0, exact latency
    set_req(0, 4'd0, 8'h7F, 8'h01);
    req_valid = 4'b0001;
    #1 chk("add_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("add_exec_no_rsp", 32'(rsp_valid), 32'd0);
    chk("exec_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'h80);
    chk("add_flags", 32'(flags()), 32'b00110);
    chk("add_id", 32'(rsp_id), 32'd0);
    handshake();
    // SUB borrow on requester 2
    run_op(2, 4'd1, 8'h00, 8'h01);
    chk("sub_result", 32'(rsp_result), 32'hFF);
    chk("sub_flags", 32'(flags()), 32'b10010);
    chk("sub_id", 32'(rsp_id), 32'd2);
    handshake();
    // unsupported opcode on requester 3
    run_op(3, 4'hA, 8'h55, 8'hAA);
    chk("ill_result", 32'(rsp_result), 32'h00);
    chk("ill_flags", 32'(flags()), 32'b01001);
    chk("ill_id", 32'(rsp_id), 32'd3);
`ifdef ALU_SCHED_STATS_EN
    chk("ill_stats_before", {8'd0, ops_count, err_count}, {8'd0, 16'd2, 8'd0});
`endif
    handshake();
`ifdef ALU_SCHED_STATS_EN
    chk("ill_stats_after", {8'd0, ops_count, err_count}, {8'd0, 16'd3, 8'd1});
`endif
    // backpressure on requester 1 while others wait
    run_op(1, 4'd0, 8'hFF, 8'h01);
    chk("bp_result", 32'(rsp_result), 32'h00);
    chk("bp_flags", 32'(flags()), 32'b11000);
    chk("bp_id", 32'(rsp_id), 32'd1);
    held_result = rsp_result;
    set_req(0, 4'd2, 8'hFF, 8'h0F);
    set_req(2, 4'd3, 8'h01, 8'h02);
    req_valid = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", {15'd0, rsp_valid, rsp_id, held_result, flags(), req_ready},
          {15'd0, 1'b1, 2'd1, 8'h00, 5'b11000, 4'b0000});
    end
    handshake();
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    req_valid = '0;
    // reset while an op sits in EXEC
    set_req(0, 4'd0, 8'h01, 8'h01);
    req_valid = 4'b0001;
    #1 chk("rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
`ifdef ALU_SCHED_STATS_EN
    chk("rst_stats", {8'd0, ops_count, err_count}, 32'd0);
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_ghost", 32'(rsp_valid), 32'd0);
    end
    // fairness with all requesters continuously valid
    set_req(0, 4'd0, 8'h10, 8'h20); fair_res[0] = 8'h30;
    set_req(1, 4'd1, 8'h05, 8'h03); fair_res[1] = 8'h02;
    set_req(2, 4'd2, 8'hF0, 8'h3C); fair_res[2] = 8'h30;
    set_req(3, 4'd3, 8'h0F, 8'h30); fair_res[3] = 8'h3F;
    req_valid = 4'b1111;
    #1 chk("fair_ptr_reset", 32'(req_ready), 32'b0001);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp();
      chk("fair_id", 32'(rsp_id), 32'(k % 4));
      chk("fair_result", 32'(rsp_result), 32'(fair_res[k % 4]));
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
